in_fifo_chain: RTL and testbench

//  Parametrised ingress FIFO chain feeding NODES processing nodes in series. Each ingress word
//  is written to stage 0; a popped word is presented to that stage's node and forwarded to the next stage.

---
 rtl/in_fifo_chain.sv | 138 +++++++++++++
 tb/tb_in_fifo_chain.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_fifo_chain.sv
// Ingress FIFO chain: NODES stage FIFOs in series, each presenting its head
// word to a processing node and forwarding it to the next stage.
module in_fifo_chain #(
    parameter int NODES   = 8,
    parameter int DW      = 128,
    parameter int CW      = 2,
    parameter int DEPTH   = 16,
    parameter int XOFF_HI = 12,
    parameter int XOFF_LO = 4,
    localparam int NCHAN  = 2 ** CW,
    localparam int EW     = CW + 2 + DW,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [CW-1:0]          in_channel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NODES*NCHAN-1:0] cfg_chan_en,
    input  logic [NODES-1:0]       pnode_ready,
    output logic [NODES*EW-1:0]    pnode_data,
    output logic [NODES-1:0]       pnode_valid,
    output logic                   xoff,
    output logic [AW:0]            occ0
);

    localparam logic [AW+1:0] LIM = (AW+2)'(DEPTH);
    localparam logic [AW:0]   HI  = (AW+1)'(XOFF_HI);
    localparam logic [AW:0]   LO  = (AW+1)'(XOFF_LO);

    logic [AW:0]       cnt   [NODES];
    logic [EW-1:0]     pdata [NODES];
    logic [NODES-2:0]  fwd;
    logic [NODES-1:0]  pend;
    logic [NODES-1:0]  space;
    logic [NODES-1:0]  pop;

    // a forward registered last cycle lands this cycle, so reserve its slot
    assign pend = {fwd, 1'b0};

    for (genvar k = 0; k < NODES; k++) begin : g_stage
        logic [EW-1:0]    mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [AW:0]      cnt_q;
        logic [EW-1:0]    head;
        logic [EW-1:0]    wdata;
        logic [EW-1:0]    data_q;
        logic [NCHAN-1:0] chan_en;
        logic             wr;
        logic             en;
        logic             empty;
        logic             room;
        logic             vld_q;

        assign space[k] = ({1'b0, cnt_q} + {{(AW + 1){1'b0}}, pend[k]}) < LIM;

        if (k == 0) begin : g_in
            assign wr    = in_valid && space[0];
            assign wdata = {in_channel, in_sop, in_eop, in_data};
        end else begin : g_fw
            assign wr    = fwd[k-1];
            assign wdata = pdata[k-1];
        end

        assign head    = mem[rd_ptr];
        assign empty   = (cnt_q == '0);
        assign chan_en = cfg_chan_en[k*NCHAN +: NCHAN];
        assign en      = chan_en[head[EW-1 -: CW]];

        if (k < NODES - 1) begin : g_mid
            logic fwd_q;

            assign room   = space[k+1];
            assign fwd[k] = fwd_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    fwd_q <= 1'b0;
                end else begin
                    fwd_q <= pop[k];
                end
            end
        end else begin : g_last
            // last stage: bypassed words are simply dropped
            assign room = 1'b1;
        end

        assign pop[k] = !empty && room && (!en || pnode_ready[k]);

        always_ff @(posedge clock) begin
            if (wr) begin
                mem[wr_ptr] <= wdata;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt_q  <= '0;
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(wr);
                rd_ptr <= rd_ptr + AW'(pop[k]);
                cnt_q  <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop[k]);
                vld_q  <= pop[k] && en;
                if (pop[k]) begin
                    data_q <= head;
                end
            end
        end

        assign cnt[k]                  = cnt_q;
        assign pdata[k]                = data_q;
        assign pnode_data[k*EW +: EW]  = data_q;
        assign pnode_valid[k]          = vld_q;
    end

    assign in_ready = space[0];
    assign occ0     = cnt[0];

    // hysteretic: between LO and HI the previous decision holds
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xoff <= 1'b0;
        end else if (cnt[0] >= HI) begin
            xoff <= 1'b1;
        end else if (cnt[0] <= LO) begin
            xoff <= 1'b0;
        end
    end

endmodule

// File: tb/tb_in_fifo_chain.sv
// Directed bench for in_fifo_chain (4 nodes, 16-bit payload, depth 16).
module tb_in_fifo_chain;

    localparam int NODES = 4;
    localparam int DW    = 16;
    localparam int CW    = 2;
    localparam int DEPTH = 16;
    localparam int EW    = CW + 2 + DW;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [DW-1:0]       in_data;
    logic                in_sop;
    logic                in_eop;
    logic [CW-1:0]       in_channel;
    logic                in_valid;
    logic                in_ready;
    logic [NODES*4-1:0]  cfg_chan_en;
    logic [NODES-1:0]    pnode_ready;
    logic [NODES*EW-1:0] pnode_data;
    logic [NODES-1:0]    pnode_valid;
    logic                xoff;
    logic [4:0]          occ0;

    in_fifo_chain #(
        .NODES(NODES), .DW(DW), .CW(CW), .DEPTH(DEPTH),
        .XOFF_HI(12), .XOFF_LO(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_channel(in_channel), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_chan_en(cfg_chan_en), .pnode_ready(pnode_ready),
        .pnode_data(pnode_data), .pnode_valid(pnode_valid),
        .xoff(xoff), .occ0(occ0)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            node;
        int            cyc;
        logic [EW-1:0] d;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        for (int k = 0; k < NODES; k++) begin
            if (pnode_valid[k] === 1'b1) begin
                evq.push_back('{k, cyc, pnode_data[k*EW +: EW]});
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nval(input int k);
        int n = 0;
        foreach (evq[i]) if (evq[i].node == k) n++;
        return n;
    endfunction

    function automatic int first_cyc(input int k);
        foreach (evq[i]) if (evq[i].node == k) return evq[i].cyc;
        return -1;
    endfunction

    function automatic logic [EW-1:0] first_data(input int k);
        foreach (evq[i]) if (evq[i].node == k) return evq[i].d;
        return '0;
    endfunction

    function automatic int in_order3(input logic [DW-1:0] base);
        int j = 0;
        foreach (evq[i]) begin
            if (evq[i].node == 3) begin
                if (evq[i].d[DW-1:0] == base + DW'(j)) j++;
                else return -1;
            end
        end
        return j;
    endfunction

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push(input logic [1:0] ch, input logic s, input logic e,
                        input logic [DW-1:0] d, output int acc);
        int n = 0;
        in_valid   = 1'b1;
        in_channel = ch;
        in_sop     = s;
        in_eop     = e;
        in_data    = d;
        while (!in_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) chk("push_timeout", 1, 0);
        @(posedge clock);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int acc;
        int i;
        logic [3:0] ch_seq [3];

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_sop      = 1'b0;
        in_eop      = 1'b0;
        in_channel  = '0;
        cfg_chan_en = '1;
        pnode_ready = '1;
        #12;
        chk("rst_valid", pnode_valid, 0);
        chk("rst_xoff", xoff, 0);
        chk("rst_occ0", occ0, 0);
        chk("rst_data", pnode_data, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // 1: single word walks the chain, 2 cycles per stage
        evq.delete();
        push(2'd1, 1'b1, 1'b1, 16'hA5C3, acc);
        idle(12);
        for (int k = 0; k < NODES; k++) begin
            chk($sformatf("t1_cnt%0d", k), nval(k), 1);
            chk($sformatf("t1_lat%0d", k), first_cyc(k) - acc, 1 + 2 * k);
            chk($sformatf("t1_dat%0d", k), first_data(k),
                {2'd1, 1'b1, 1'b1, 16'hA5C3});
        end

        // 2: node1 stalled, stream 40 words, backpressure then release
        evq.delete();
        pnode_ready = 4'b1101;
        i = 0;
        for (int c = 0; c < 80; c++) begin
            in_valid   = (i < 40) && in_ready;
            in_channel = 2'd1;
            in_sop     = (i == 0);
            in_eop     = (i == 39);
            in_data    = 16'h0100 + DW'(i);
            @(posedge clock);
            #1;
            if (in_valid) i++;
        end
        in_valid = 1'b0;
        chk("t2_accepted", i, 32);
        chk("t2_occ0", occ0, 16);
        chk("t2_in_ready", in_ready, 0);
        chk("t2_stage1", dut.g_stage[1].cnt_q, 16);
        chk("t2_node0_pulses", nval(0), 16);
        chk("t2_node1_pulses", nval(1), 0);
        pnode_ready = 4'b1111;
        for (int c = 0; c < 200 && i < 40; c++) begin
            in_valid   = in_ready;
            in_channel = 2'd1;
            in_sop     = 1'b0;
            in_eop     = (i == 39);
            in_data    = 16'h0100 + DW'(i);
            @(posedge clock);
            #1;
            if (in_valid) i++;
        end
        in_valid = 1'b0;
        idle(40);
        chk("t2_total", i, 40);
        chk("t2_node3_pulses", nval(3), 40);
        chk("t2_order", in_order3(16'h0100), 40);

        // 3: node2 consumes ch0 only
        evq.delete();
        cfg_chan_en = 16'hF1FF;
        pnode_ready = 4'b1011;
        push(2'd3, 1'b1, 1'b1, 16'h0333, acc);
        idle(16);
        chk("t3_bypass_n2", nval(2), 0);
        chk("t3_bypass_n3", nval(3), 1);
        chk("t3_bypass_dat", first_data(3), {2'd3, 1'b1, 1'b1, 16'h0333});
        evq.delete();
        pnode_ready = 4'b1111;
        ch_seq[0] = 4'd0;
        ch_seq[1] = 4'd3;
        ch_seq[2] = 4'd0;
        for (int w = 0; w < 3; w++) begin
            push(ch_seq[w][1:0], 1'b1, 1'b1, 16'h0300 + DW'(w), acc);
        end
        idle(16);
        chk("t3_n2_pulses", nval(2), 2);
        chk("t3_n3_pulses", nval(3), 3);
        chk("t3_n3_order", in_order3(16'h0300), 3);
        cfg_chan_en = '1;

        // 4: xoff hysteresis on stage-0 occupancy
        pnode_ready = 4'b0000;
        for (int w = 0; w < 12; w++) begin
            push(2'd0, 1'b0, 1'b0, DW'(w), acc);
        end
        chk("t4_occ12", occ0, 12);
        chk("t4_xoff_pre", xoff, 0);
        idle(1);
        chk("t4_xoff_set", xoff, 1);
        repeat (7) begin
            pnode_ready = 4'b0001;
            @(posedge clock);
            #1;
            pnode_ready = 4'b0000;
        end
        chk("t4_occ5", occ0, 5);
        idle(1);
        chk("t4_xoff_at5", xoff, 1);
        pnode_ready = 4'b0001;
        @(posedge clock);
        #1;
        pnode_ready = 4'b0000;
        chk("t4_occ4", occ0, 4);
        chk("t4_xoff_hold", xoff, 1);
        idle(1);
        chk("t4_xoff_clr", xoff, 0);

        // 5: asynchronous reset mid-stream
        for (int w = 0; w < 10; w++) begin
            push(2'd2, 1'b0, 1'b0, DW'(w), acc);
        end
        idle(1);
        chk("t5_xoff_pre", xoff, 1);
        pnode_ready = 4'b0001;
        idle(1);
        chk("t5_valid_pre", pnode_valid[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_valid", pnode_valid, 0);
        chk("t5_xoff", xoff, 0);
        chk("t5_occ0", occ0, 0);
        chk("t5_data", pnode_data, 0);
        @(negedge clock);
        reset_n     = 1'b1;
        pnode_ready = 4'b1111;
        @(posedge clock);
        #1;
        chk("t5_in_ready", in_ready, 1);
        evq.delete();
        push(2'd1, 1'b1, 1'b0, 16'h5555, acc);
        idle(12);
        chk("t5_lat0", first_cyc(0) - acc, 1);
        chk("t5_n3_pulses", nval(3), 1);

        // 6: channel disabled at the last node is discarded
        evq.delete();
        cfg_chan_en = 16'hBFFF;
        push(2'd2, 1'b1, 1'b1, 16'h0666, acc);
        idle(16);
        chk("t6_n2_pulses", nval(2), 1);
        chk("t6_n3_pulses", nval(3), 0);
        chk("t6_last_cnt", dut.g_stage[3].cnt_q, 0);
        push(2'd1, 1'b1, 1'b1, 16'h0667, acc);
        idle(16);
        chk("t6_n3_enabled", nval(3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
